// File: rtl/axi4_ram_slave_if.sv
// AXI4 bus bundle carrying clock, reset and all five channels.
interface axi4 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic ACLK,
  input logic ARESETN
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [ID_WIDTH-1:0]     AWID;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWLOCK;
  logic [3:0]              AWCACHE;
  logic [2:0]              AWPROT;
  logic [3:0]              AWQOS;
  logic [3:0]              AWREGION;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [ID_WIDTH-1:0]     ARID;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARLOCK;
  logic [3:0]              ARCACHE;
  logic [2:0]              ARPROT;
  logic [3:0]              ARQOS;
  logic [3:0]              ARREGION;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [ID_WIDTH-1:0]     RID;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  ACLK, ARESETN,
    input  AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
    output ARREADY,
    output RDATA, RID, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    input  ACLK, ARESETN,
    output AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARVALID,
    input  ARREADY,
    input  RDATA, RID, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_ram_slave.sv
// AXI4 responder on a single-port RAM: one transaction at a time, reads and
// writes arbitrated round-robin, FIXED/INCR/WRAP bursts with narrow sizes.
module axi4_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  axi4.slave s_axi
);
  localparam int NB     = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NB);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    w_clk;
  logic                    w_rst_n;
  logic                    r_prio_w;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ID_WIDTH-1:0]     r_id;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic                    r_err;
  logic                    r_rd_first;
  logic                    r_rvalid;
  logic                    r_rlast;
  logic [1:0]              r_rresp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_idle;
  logic                    w_aw_grant;
  logic                    w_ar_grant;
  logic                    w_w_hs;
  logic                    w_r_hs;
  logic                    w_last_cnt;
  logic                    w_in_range;
  logic                    w_rd_issue;
  logic [MEM_AW-1:0]       w_idx;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_unused;

  assign w_clk   = s_axi.ACLK;
  assign w_rst_n = s_axi.ARESETN;

  // Address of the beat after a, following AXI burst rules on a byte address.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            sz,
    input logic [1:0]            bu,
    input logic [7:0]            len
  );
    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wb;
    logic                  wrap_ok;
    bytes   = ADDR_WIDTH'(1) << sz;
    wb      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << sz;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (bu == 2'b00) begin
      f_next_addr = a;
    end else if (bu == 2'b10 && wrap_ok) begin
      f_next_addr = (a & ~(wb - ADDR_WIDTH'(1))) | ((a + bytes) & (wb - ADDR_WIDTH'(1)));
    end else begin
      f_next_addr = (a & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    end
  endfunction

  // Ready is gated by reset so it reads 0 while ARESETN is low even if a
  // master holds VALID.
  assign w_idle     = (r_state == IDLE);
  assign w_aw_grant = w_idle & w_rst_n & s_axi.AWVALID & (~s_axi.ARVALID | r_prio_w);
  assign w_ar_grant = w_idle & w_rst_n & s_axi.ARVALID & (~s_axi.AWVALID | ~r_prio_w);
  assign w_w_hs     = (r_state == WDATA) & s_axi.WVALID;
  assign w_r_hs     = r_rvalid & s_axi.RREADY;
  assign w_last_cnt = (r_cnt == r_len);
  assign w_in_range = ((r_addr >> (LSB + MEM_AW)) == '0);
  assign w_idx      = r_addr[LSB +: MEM_AW];
  assign w_next_addr = f_next_addr(r_addr, r_size, r_burst, r_len);
  assign w_rd_issue = (r_state == RDATA) & (r_rd_first | (w_r_hs & ~r_rlast));

  assign w_unused = ^{s_axi.AWLOCK, s_axi.AWCACHE, s_axi.AWPROT, s_axi.AWQOS, s_axi.AWREGION,
                      s_axi.ARLOCK, s_axi.ARCACHE, s_axi.ARPROT, s_axi.ARQOS, s_axi.ARREGION};

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_grant) begin
          w_state_nxt = WDATA;
        end else if (w_ar_grant) begin
          w_state_nxt = RDATA;
        end
      end
      WDATA: begin
        if (w_w_hs && w_last_cnt) begin
          w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        if (s_axi.BREADY) begin
          w_state_nxt = IDLE;
        end
      end
      RDATA: begin
        if (w_r_hs && r_rlast) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prio_w   <= 1'b1;
      r_addr     <= '0;
      r_id       <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_rd_first <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_aw_grant || w_ar_grant) begin
        r_prio_w <= ~r_prio_w;
      end
      if (w_aw_grant) begin
        r_addr  <= s_axi.AWADDR;
        r_id    <= s_axi.AWID;
        r_len   <= s_axi.AWLEN;
        r_size  <= (s_axi.AWSIZE > MAX_SIZE) ? MAX_SIZE : s_axi.AWSIZE;
        r_burst <= s_axi.AWBURST;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end else if (w_ar_grant) begin
        r_addr     <= s_axi.ARADDR;
        r_id       <= s_axi.ARID;
        r_len      <= s_axi.ARLEN;
        r_size     <= (s_axi.ARSIZE > MAX_SIZE) ? MAX_SIZE : s_axi.ARSIZE;
        r_burst    <= s_axi.ARBURST;
        r_cnt      <= '0;
        r_rd_first <= 1'b1;
      end

      // The beat counter, not WLAST, ends the burst; a WLAST mismatch only flags.
      if (w_w_hs) begin
        r_addr <= w_next_addr;
        r_cnt  <= r_cnt + 8'd1;
        if (!w_in_range || (s_axi.WLAST != w_last_cnt)) begin
          r_err <= 1'b1;
        end
      end

      if (w_r_hs && r_rlast) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end

      // r_addr always points at the next beat to fetch, so the RAM read for
      // beat n+1 launches in the same cycle beat n is accepted.
      if (w_rd_issue) begin
        r_rd_first <= 1'b0;
        r_rvalid   <= 1'b1;
        r_rlast    <= w_last_cnt;
        r_rdata    <= w_in_range ? r_mem[w_idx] : '0;
        r_rresp    <= w_in_range ? RESP_OKAY : RESP_SLVERR;
        r_addr     <= w_next_addr;
        r_cnt      <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_w_hs && w_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi.WSTRB[b]) begin
          r_mem[w_idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
        end
      end
    end
  end

  assign s_axi.AWREADY = w_aw_grant;
  assign s_axi.ARREADY = w_ar_grant;
  assign s_axi.WREADY  = (r_state == WDATA);
  assign s_axi.BVALID  = (r_state == WRESP);
  assign s_axi.BID     = r_id;
  assign s_axi.BRESP   = ((r_state == WRESP) && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.RVALID  = r_rvalid;
  assign s_axi.RDATA   = r_rdata;
  assign s_axi.RRESP   = r_rresp;
  assign s_axi.RLAST   = r_rlast;
  assign s_axi.RID     = r_id;
endmodule

// File: tb/tb_axi4_ram_slave.sv
// Directed self-checking bench for axi4_ram_slave.
module tb_axi4_ram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi4 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus (.ACLK(clk), .ARESETN(rst_n));

  axi4_ram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(1024)) dut (.s_axi(bus));

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic        wr_last [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  initial begin
    bus.AWADDR = '0; bus.AWID = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWLOCK = '0; bus.AWCACHE = '0; bus.AWPROT = '0; bus.AWQOS = '0; bus.AWREGION = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARID = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARLOCK = '0; bus.ARCACHE = '0; bus.ARPROT = '0; bus.ARQOS = '0; bus.ARREGION = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
  end

  // All driver tasks start and end just after a falling edge.
  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] bu, output int hs);
    bit ok = 0;
    hs = -1;
    bus.AWADDR = a; bus.AWID = id; bus.AWLEN = len; bus.AWSIZE = 3'd2; bus.AWBURST = bu;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.AWREADY) begin hs = cyc + 1; ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    bus.AWVALID = 1'b0;
    if (!ok) begin n_tests++; n_fail++; $display("FAIL aw_timeout: no AWREADY within 50 cycles"); end
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] bu, output int hs);
    bit ok = 0;
    hs = -1;
    bus.ARADDR = a; bus.ARID = id; bus.ARLEN = len; bus.ARSIZE = 3'd2; bus.ARBURST = bu;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.ARREADY) begin hs = cyc + 1; ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    bus.ARVALID = 1'b0;
    if (!ok) begin n_tests++; n_fail++; $display("FAIL ar_timeout: no ARREADY within 50 cycles"); end
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l, output int hs);
    bit ok = 0;
    hs = -1;
    bus.WDATA = d; bus.WSTRB = s; bus.WLAST = l; bus.WVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.WREADY) begin hs = cyc + 1; ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    bus.WVALID = 1'b0;
    if (!ok) begin n_tests++; n_fail++; $display("FAIL w_timeout: no WREADY within 50 cycles"); end
  endtask

  task automatic b_recv(output int first, output logic [3:0] bid, output logic [1:0] bresp);
    bit ok = 0;
    first = -1; bid = 'x; bresp = 'x;
    bus.BREADY = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.BVALID) begin first = cyc; bid = bus.BID; bresp = bus.BRESP; ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    bus.BREADY = 1'b0;
    if (!ok) begin n_tests++; n_fail++; $display("FAIL b_timeout: no BVALID within 50 cycles"); end
  endtask

  task automatic r_recv(input int n, input bit toggle, output int first, output int got, output int unstable);
    bit          held = 0;
    logic [31:0] hd = '0;
    logic [1:0]  hr = '0;
    logic        hl = 1'b0;
    first = -1; got = 0; unstable = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      bus.RREADY = toggle ? ((i % 2) == 0) : 1'b1;
      #1;
      if (held && (!bus.RVALID || bus.RDATA !== hd || bus.RRESP !== hr || bus.RLAST !== hl)) unstable++;
      held = 0;
      if (bus.RVALID && first < 0) first = cyc;
      if (bus.RVALID && bus.RREADY) begin
        rd_data[got] = bus.RDATA; rd_resp[got] = bus.RRESP; rd_last[got] = bus.RLAST; rd_id[got] = bus.RID;
        got++;
      end else if (bus.RVALID) begin
        held = 1; hd = bus.RDATA; hr = bus.RRESP; hl = bus.RLAST;
      end
      @(negedge clk);
    end
    bus.RREADY = 1'b0;
    if (got < n) begin n_tests++; n_fail++; $display("FAIL r_timeout: got %0d beats want %0d", got, n); end
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] bu, output int aw_hs, output logic wr_rdy,
                             output int w_last_hs, output int b_first, output logic [3:0] bid,
                             output logic [1:0] bresp);
    int hs;
    aw_send(a, id, len, bu, aw_hs);
    wr_rdy = bus.WREADY && (cyc == aw_hs);
    w_last_hs = -1;
    for (int i = 0; i <= int'(len); i++) begin
      w_send(wr_data[i], wr_strb[i], wr_last[i], hs);
      w_last_hs = hs;
    end
    b_recv(b_first, bid, bresp);
  endtask

  task automatic test_reset();
    int hs;
    rst_n = 1'b0;
    bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 000000", {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST});
    end
    n_tests++;
    if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0) begin
      n_fail++; $display("FAIL reset_data: got bresp=%0h rresp=%0h rdata=%0h want 0", bus.BRESP, bus.RRESP, bus.RDATA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b10) begin
      n_fail++; $display("FAIL reset_first_grant: got awready/arready=%b want 10", {bus.AWREADY, bus.ARREADY});
    end
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    @(negedge clk);
    aw_send(32'h500, 4'd1, 8'd3, 2'b01, hs);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.WREADY, bus.AWREADY} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_write: got wready/awready=%b want 00", {bus.WREADY, bus.AWREADY});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_incr();
    int aw_hs, wl, bf, ar_hs, first, got, unst;
    logic wr_rdy;
    logic [3:0] bid;
    logic [1:0] bresp;
    for (int i = 0; i < 4; i++) begin
      wr_data[i] = 32'hA0 + i; wr_strb[i] = 4'hF; wr_last[i] = (i == 3);
    end
    write_burst(32'h100, 4'd5, 8'd3, 2'b01, aw_hs, wr_rdy, wl, bf, bid, bresp);
    n_tests++;
    if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL incr_wready_t1: got %b want 1", wr_rdy); end
    n_tests++;
    if (wl - aw_hs !== 4) begin n_fail++; $display("FAIL incr_w_beats: last W at T+%0d want T+4", wl - aw_hs); end
    n_tests++;
    if (bf !== wl) begin n_fail++; $display("FAIL incr_b_latency: BVALID seen at %0d want %0d", bf, wl); end
    n_tests++;
    if ({bid, bresp} !== {4'd5, 2'b00}) begin n_fail++; $display("FAIL incr_b: got bid=%0d bresp=%0d want 5/0", bid, bresp); end

    ar_send(32'h100, 4'd9, 8'd3, 2'b01, ar_hs);
    r_recv(4, 1'b0, first, got, unst);
    n_tests++;
    if (first !== ar_hs + 1) begin n_fail++; $display("FAIL incr_r_latency: RVALID seen at %0d want %0d", first, ar_hs + 1); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({rd_data[i], rd_resp[i], rd_last[i], rd_id[i]} !== {32'hA0 + 32'(i), 2'b00, (i == 3), 4'd9}) begin
        n_fail++;
        $display("FAIL incr_r_beat%0d: got data=%0h resp=%0d last=%b id=%0d want %0h/0/%b/9", i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], 32'hA0 + i, i == 3);
      end
    end
    #1;
    n_tests++;
    if (bus.RVALID !== 1'b0) begin n_fail++; $display("FAIL incr_r_extra: RVALID=%b after last beat want 0", bus.RVALID); end
  endtask

  task automatic test_wrap_fixed();
    int aw_hs, wl, bf, ar_hs, first, got, unst;
    logic wr_rdy;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic [31:0] exp [4];
    exp = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    ar_send(32'h108, 4'd3, 8'd3, 2'b10, ar_hs);
    r_recv(4, 1'b0, first, got, unst);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_data[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_beat%0d: got %0h want %0h", i, rd_data[i], exp[i]); end
    end

    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    write_burst(32'h200, 4'd2, 8'd0, 2'b01, aw_hs, wr_rdy, wl, bf, bid, bresp);
    wr_data[0] = 32'h000000AA; wr_strb[0] = 4'h1; wr_last[0] = 1'b0;
    wr_data[1] = 32'h0000BB00; wr_strb[1] = 4'h2; wr_last[1] = 1'b0;
    wr_data[2] = 32'h00CC0000; wr_strb[2] = 4'h4; wr_last[2] = 1'b1;
    write_burst(32'h200, 4'd2, 8'd2, 2'b00, aw_hs, wr_rdy, wl, bf, bid, bresp);
    n_tests++;
    if (bresp !== 2'b00) begin n_fail++; $display("FAIL fixed_bresp: got %0d want 0", bresp); end
    ar_send(32'h200, 4'd2, 8'd0, 2'b01, ar_hs);
    r_recv(1, 1'b0, first, got, unst);
    n_tests++;
    if (rd_data[0] !== 32'hDECCBBAA) begin n_fail++; $display("FAIL fixed_merge: got %0h want DECCBBAA", rd_data[0]); end
  endtask

  task automatic test_arb();
    int hs, bf, first, got, unst;
    logic [3:0] bid;
    logic [1:0] bresp;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.AWADDR = 32'h300; bus.AWID = 4'd1; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
    bus.ARADDR = 32'h100; bus.ARID = 4'd2; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01;
    bus.AWVALID = 1'b1; bus.ARVALID = 1'b1;
    #1;
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b10) begin n_fail++; $display("FAIL arb_grant1: got aw/ar=%b want 10", {bus.AWREADY, bus.ARREADY}); end
    @(negedge clk);
    bus.AWVALID = 1'b0;
    w_send(32'h33333333, 4'hF, 1'b1, hs);
    b_recv(bf, bid, bresp);
    bus.AWADDR = 32'h304; bus.AWVALID = 1'b1;
    #1;
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b01) begin n_fail++; $display("FAIL arb_grant2: got aw/ar=%b want 01", {bus.AWREADY, bus.ARREADY}); end
    @(negedge clk);
    bus.ARVALID = 1'b0;
    r_recv(1, 1'b0, first, got, unst);
    n_tests++;
    if (rd_data[0] !== 32'hA0) begin n_fail++; $display("FAIL arb_rdata: got %0h want A0", rd_data[0]); end
    bus.ARVALID = 1'b1;
    #1;
    n_tests++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b10) begin n_fail++; $display("FAIL arb_grant3: got aw/ar=%b want 10", {bus.AWREADY, bus.ARREADY}); end
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
    w_send(32'h44444444, 4'hF, 1'b1, hs);
    b_recv(bf, bid, bresp);
  endtask

  task automatic test_backpressure();
    int ar_hs, first, got, unst;
    ar_send(32'h100, 4'd7, 8'd3, 2'b01, ar_hs);
    r_recv(4, 1'b1, first, got, unst);
    n_tests++;
    if (unst !== 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable held beats want 0", unst); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({rd_data[i], rd_last[i]} !== {32'hA0 + 32'(i), (i == 3)}) begin
        n_fail++; $display("FAIL bp_beat%0d: got %0h last=%b want %0h last=%b", i, rd_data[i], rd_last[i], 32'hA0 + i, i == 3);
      end
    end
  endtask

  task automatic test_errors();
    int aw_hs, wl, bf, ar_hs, first, got, unst;
    logic wr_rdy;
    logic [3:0] bid;
    logic [1:0] bresp;
    wr_data[0] = 32'h1; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    wr_data[1] = 32'h2; wr_strb[1] = 4'hF; wr_last[1] = 1'b1;
    write_burst(32'h400, 4'd4, 8'd1, 2'b01, aw_hs, wr_rdy, wl, bf, bid, bresp);
    n_tests++;
    if (wl - aw_hs !== 2) begin n_fail++; $display("FAIL err_wlast_beats: last W at T+%0d want T+2", wl - aw_hs); end
    n_tests++;
    if ({bid, bresp} !== {4'd4, 2'b10}) begin n_fail++; $display("FAIL err_wlast_bresp: got bid=%0d bresp=%0d want 4/2", bid, bresp); end

    wr_data[0] = 32'h77777777; wr_strb[0] = 4'hF; wr_last[0] = 1'b1;
    write_burst(32'h1000, 4'd6, 8'd0, 2'b01, aw_hs, wr_rdy, wl, bf, bid, bresp);
    n_tests++;
    if (bresp !== 2'b10) begin n_fail++; $display("FAIL err_oor_write: got bresp=%0d want 2", bresp); end

    wr_data[0] = 32'h5A5A5A5A;
    write_burst(32'hFFC, 4'd6, 8'd0, 2'b01, aw_hs, wr_rdy, wl, bf, bid, bresp);
    n_tests++;
    if (bresp !== 2'b00) begin n_fail++; $display("FAIL err_flag_clear: got bresp=%0d want 0", bresp); end

    ar_send(32'hFFC, 4'd8, 8'd1, 2'b01, ar_hs);
    r_recv(2, 1'b0, first, got, unst);
    n_tests++;
    if ({rd_data[0], rd_resp[0], rd_last[0]} !== {32'h5A5A5A5A, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL err_oor_beat0: got %0h resp=%0d last=%b want 5A5A5A5A/0/0", rd_data[0], rd_resp[0], rd_last[0]);
    end
    n_tests++;
    if ({rd_data[1], rd_resp[1], rd_last[1]} !== {32'h0, 2'b10, 1'b1}) begin
      n_fail++; $display("FAIL err_oor_beat1: got %0h resp=%0d last=%b want 0/2/1", rd_data[1], rd_resp[1], rd_last[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    int ar_hs, first, got, unst, beats;
    bit hit = 0;
    ar_send(32'h100, 4'd3, 8'd7, 2'b01, ar_hs);
    bus.RREADY = 1'b1;
    beats = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.RVALID) begin
        if (beats == 2) begin hit = 1; break; end
        beats++;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL rst_read_reach: saw %0d beats want beat 2", beats); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.RVALID, bus.RLAST, bus.RDATA, bus.RRESP} !== 36'h0) begin
      n_fail++; $display("FAIL rst_read_outputs: got rvalid=%b rlast=%b rdata=%0h rresp=%0d want 0", bus.RVALID, bus.RLAST, bus.RDATA, bus.RRESP);
    end
    bus.RREADY = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ar_send(32'h100, 4'd11, 8'd3, 2'b01, ar_hs);
    r_recv(4, 1'b0, first, got, unst);
    n_tests++;
    if (first !== ar_hs + 1) begin n_fail++; $display("FAIL rst_read_latency: RVALID seen at %0d want %0d", first, ar_hs + 1); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({rd_data[i], rd_last[i], rd_id[i]} !== {32'hA0 + 32'(i), (i == 3), 4'd11}) begin
        n_fail++; $display("FAIL rst_read_beat%0d: got %0h last=%b id=%0d want %0h/%b/11", i, rd_data[i], rd_last[i], rd_id[i], 32'hA0 + i, i == 3);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_incr();
    test_wrap_fixed();
    test_arb();
    test_backpressure();
    test_errors();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
